rgb_pwm_driver: RTL and testbench
=================================

// Module: rgb_pwm_driver
//
// PURPOSE
//   Downstream stage of the lights selector. It converts the 24-bit RGB code on
//   `light` into three PWM drive signals for a physical RGB LED.
//   Duty changes are applied only at PWM frame boundaries and ramp by FADE_STEP
//   per frame, so colour changes fade instead of stepping.
//   A one-cycle frame_tick and a busy flag let higher levels pace updates.
//
// PARAMETERS
//   PRESCALE   4  clk cycles per PWM count; legal range 1..65535
//   FADE_STEP  8  max duty change per channel per frame; legal range 1..255
//                 (255 = effectively instant)
//
// PORTS
//   clk         in   1   system clock; all logic on the rising edge
//   rst         in   1   asynchronous, active-high reset
//   light       in   24  target colour {R[23:16], G[15:8], B[7:0]}
//   enable      in   1   1 = run PWM; 0 = outputs off, frame counter held at 0
//   led_r       out  1   red PWM drive, registered
//   led_g       out  1   green PWM drive, registered
//   led_b       out  1   blue PWM drive, registered
//   frame_tick  out  1   one-cycle pulse at each PWM frame start, registered
//   busy        out  1   1 while any duty differs from the last sampled target
//
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - Clears pre_cnt, pwm_cnt[7:0], duty_r/g/b[7:0] and tgt[23:0].
//     - Outputs led_*, frame_tick and busy are all 0.
//   Counting
//     - pre_cnt counts 0..PRESCALE-1; tick = (pre_cnt == PRESCALE-1) && enable.
//     - On tick, pwm_cnt increments and wraps 255 -> 0.
//     - Frame length = 256*PRESCALE clk.
//   Frame boundary (wrap)
//     - wrap = tick && (pwm_cnt == 255).
//     - On wrap: tgt <= light.
//     - On wrap, each duty_x steps toward light_x (the value sampled in the same cycle):
//         - if duty < t: duty <= min(duty + FADE_STEP, t)
//         - if duty > t: duty <= max(duty - FADE_STEP, t)
//         - if duty == t: duty unchanged
//     - Arithmetic is 9-bit, with no wrap-around; the result is clamped to t.
//     - light is ignored between wraps; mid-frame changes are not seen until the next wrap.
//   Outputs
//     - frame_tick = 1 for the single cycle after wrap (when pwm_cnt == 0 first appears).
//     - led_x <= enable && (pwm_cnt < duty_x), registered: 1 clk behind the counter.
//         - duty 0 -> constant 0.
//         - duty 255 -> high 255 of 256 counts (never a constant 1).
//         - duty D -> high for D*PRESCALE clk per frame.
//     - busy <= (duty_r != tgt[23:16]) || (duty_g != tgt[15:8]) || (duty_b != tgt[7:0]).
//   Enable low
//     - Synchronously clears pre_cnt and pwm_cnt; the next cycle drives led_* = 0.
//     - No tick, no wrap, no frame_tick; duty and tgt are held.
//     - On re-enable, a fresh frame starts at pwm_cnt = 0 with no frame_tick for that
//       first partial start.
//   Corner cases
//     - PRESCALE = 1: tick every enabled cycle.
//     - Reset mid-frame aborts the frame immediately; duties restart from 0 (fade-in
//       from black).
//
// TESTING (default PRESCALE=1 unless stated)
//   1. Reset: rst pulse mid-frame with duty nonzero -> led_*, frame_tick, busy = 0
//      asynchronously; pwm_cnt = 0.
//   2. Instant colour: FADE_STEP=255, light=24'hFF8000.
//      -> After first wrap, each 256-cycle frame has led_r high 255, led_g high 128,
//         led_b high 0 cycles.
//   3. Fade: FADE_STEP=8, light 0 -> 24'h1A0000.
//      -> duty_r = 8, 16, 24, 26 on successive wraps.
//      -> busy = 1 until the frame with duty_r = 26, then 0.
//   4. Fade down, no underflow: duty_g = 5, FADE_STEP=8, light = 0.
//      -> duty_g = 0 after one wrap (not 253).
//   5. Enable gap: drop enable at pwm_cnt = 100 for 50 cycles.
//      -> led_* = 0, no frame_tick during the gap.
//      -> On re-enable, pwm_cnt restarts at 0 and the next frame_tick comes 256 cycles later.
//   6. PRESCALE=4: frame_tick period = 1024 clk; duty 64 -> led high 256 clk per frame.

Source files
------------

// File: rtl/rgb_pwm_driver.sv
// Converts a 24-bit RGB target into three PWM LED drives, fading each duty toward the target once per frame.
// Latency: led_* one clk behind the PWM counter, duty changes only at frame wrap; no backpressure, light is sampled at wrap only.
module rgb_pwm_driver #(
  parameter int PRESCALE  = 4,
  parameter int FADE_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        enable,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        frame_tick,
  output logic        busy
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [8:0]  STEP    = 9'(FADE_STEP);

  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty_r, duty_g, duty_b;
  logic [23:0] tgt;
  logic        tick, wrap;
  logic [7:0]  nxt_r, nxt_g, nxt_b;

  assign tick = enable && (pre_cnt == PRE_MAX);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  // One fade step toward t; a negative difference shows up as bit 8 set and clamps to t.
  function automatic logic [7:0] fade(input logic [7:0] d, input logic [7:0] t);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, d} + STEP;
    dn = {1'b0, d} - STEP;
    if (d < t)
      return (up > {1'b0, t}) ? t : up[7:0];
    else if (d > t)
      return (dn[8] || (dn < {1'b0, t})) ? t : dn[7:0];
    else
      return d;
  endfunction

  always_comb begin
    nxt_r = fade(duty_r, light[23:16]);
    nxt_g = fade(duty_g, light[15:8]);
    nxt_b = fade(duty_b, light[7:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!enable) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_r <= '0;
      duty_g <= '0;
      duty_b <= '0;
      tgt    <= '0;
    end else if (wrap) begin
      duty_r <= nxt_r;
      duty_g <= nxt_g;
      duty_b <= nxt_b;
      tgt    <= light;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_r      <= 1'b0;
      led_g      <= 1'b0;
      led_b      <= 1'b0;
      frame_tick <= 1'b0;
      busy       <= 1'b0;
    end else begin
      led_r      <= enable && (pwm_cnt < duty_r);
      led_g      <= enable && (pwm_cnt < duty_g);
      led_b      <= enable && (pwm_cnt < duty_b);
      frame_tick <= wrap;
      busy       <= (duty_r != tgt[23:16]) || (duty_g != tgt[15:8]) || (duty_b != tgt[7:0]);
    end
  end

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: three instances cover instant colour, fading and PRESCALE=4.
`timescale 1ns/1ps
module tb_rgb_pwm_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [3];
  logic [23:0] light_v [3];
  logic        en_v    [3];
  wire         lr [3];
  wire         lg [3];
  wire         lb [3];
  wire         ft [3];
  wire         bz [3];

  rgb_pwm_driver #(.PRESCALE(1), .FADE_STEP(255)) dut_a (
    .clk(clk), .rst(rst_v[0]), .light(light_v[0]), .enable(en_v[0]),
    .led_r(lr[0]), .led_g(lg[0]), .led_b(lb[0]), .frame_tick(ft[0]), .busy(bz[0]));
  rgb_pwm_driver #(.PRESCALE(1), .FADE_STEP(8)) dut_b (
    .clk(clk), .rst(rst_v[1]), .light(light_v[1]), .enable(en_v[1]),
    .led_r(lr[1]), .led_g(lg[1]), .led_b(lb[1]), .frame_tick(ft[1]), .busy(bz[1]));
  rgb_pwm_driver #(.PRESCALE(4), .FADE_STEP(255)) dut_c (
    .clk(clk), .rst(rst_v[2]), .light(light_v[2]), .enable(en_v[2]),
    .led_r(lr[2]), .led_g(lg[2]), .led_b(lb[2]), .frame_tick(ft[2]), .busy(bz[2]));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] light;
    int          er, eg, eb;
    logic        ebusy;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Counts negedges until frame_tick is seen, and red-LED high cycles on the way.
  task automatic wait_tick(input int d, input int max, output int n, output int hr);
    n  = 0;
    hr = 0;
    do begin
      @(negedge clk);
      n++;
      hr += int'(lr[d]);
    end while (!ft[d] && n < max);
    if (!ft[d]) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: dut %0d no frame_tick within %0d cycles", d, max);
    end
  endtask

  // Starting on a frame_tick sample, observe one full frame of plen clocks.
  task automatic measure(input int d, input int plen, input int chg_at, input logic [23:0] chg_light,
                         output int cr, output int cg, output int cb,
                         output logic bmid, output int extra, output logic endt);
    cr = 0; cg = 0; cb = 0; extra = 0; bmid = 1'b0; endt = 1'b0;
    for (int i = 1; i <= plen; i++) begin
      @(negedge clk);
      cr += int'(lr[d]);
      cg += int'(lg[d]);
      cb += int'(lb[d]);
      if (i == plen / 2) bmid = bz[d];
      if (i < plen) extra += int'(ft[d]);
      else endt = ft[d];
      if (i == chg_at) light_v[d] = chg_light;
    end
  endtask

  task automatic chk_frame(input string tag, input int d, input int plen, input int chg_at,
                           input logic [23:0] chg_light, input int er, input int eg, input int eb,
                           input logic ebusy);
    int cr, cg, cb, extra;
    logic bmid, endt;
    measure(d, plen, chg_at, chg_light, cr, cg, cb, bmid, extra, endt);
    chk({tag, "_r_high"}, cr, er);
    chk({tag, "_g_high"}, cg, eg);
    chk({tag, "_b_high"}, cb, eb);
    chk1({tag, "_busy"}, bmid, ebusy);
    chk({tag, "_midframe_ticks"}, extra, 0);
    chk1({tag, "_next_tick"}, endt, 1'b1);
  endtask

  initial begin
    int n, hr;
    logic quiet;

    tbl[0] = '{24'h1A0000,  8, 0, 0, 1'b1};
    tbl[1] = '{24'h1A0000, 16, 0, 0, 1'b1};
    tbl[2] = '{24'h1A0000, 24, 0, 0, 1'b1};
    tbl[3] = '{24'h1A0000, 26, 0, 0, 1'b0};
    tbl[4] = '{24'h1A0503, 26, 0, 0, 1'b0};
    tbl[5] = '{24'h000000, 26, 5, 3, 1'b0};
    tbl[6] = '{24'h000000, 18, 0, 0, 1'b1};
    tbl[7] = '{24'h000000, 10, 0, 0, 1'b1};
    tbl[8] = '{24'h000000,  2, 0, 0, 1'b1};
    tbl[9] = '{24'h000000,  0, 0, 0, 1'b0};

    for (int d = 0; d < 3; d++) begin
      rst_v[d]   = 1'b1;
      en_v[d]    = 1'b0;
      light_v[d] = 24'h0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk1("reset_outputs", lr[d] | lg[d] | lb[d] | ft[d] | bz[d], 1'b0);
    end

    // Fade sequence, table driven
    light_v[1] = 24'h1A0000;
    en_v[1]    = 1'b1;
    rst_v[1]   = 1'b0;
    wait_tick(1, 600, n, hr);
    chk("b_first_tick_delay", n, 256);
    chk("b_first_frame_r", hr, 0);
    for (int i = 0; i < 10; i++) begin
      light_v[1] = tbl[i].light;
      chk_frame($sformatf("fade%0d", i), 1, 256, 0, 24'h0,
                tbl[i].er, tbl[i].eg, tbl[i].eb, tbl[i].ebusy);
    end

    // Instant colour, enable gap, mid-frame light change
    light_v[0] = 24'hFF8000;
    en_v[0]    = 1'b1;
    rst_v[0]   = 1'b0;
    wait_tick(0, 600, n, hr);
    chk("a_first_tick_delay", n, 256);
    chk_frame("instant", 0, 256, 0, 24'h0, 255, 128, 0, 1'b0);
    repeat (100) @(negedge clk);
    en_v[0] = 1'b0;
    quiet   = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      quiet = quiet | lr[0] | lg[0] | lb[0] | ft[0];
    end
    chk1("gap_quiet", quiet, 1'b0);
    en_v[0] = 1'b1;
    wait_tick(0, 600, n, hr);
    chk("reenable_tick_delay", n, 256);
    chk("reenable_frame_r", hr, 255);
    chk_frame("light_midframe", 0, 256, 100, 24'h000000, 255, 128, 0, 1'b0);
    chk_frame("after_change", 0, 256, 0, 24'h0, 0, 0, 0, 1'b0);

    // PRESCALE=4 frame and mid-frame reset
    light_v[2] = 24'h404040;
    en_v[2]    = 1'b1;
    rst_v[2]   = 1'b0;
    wait_tick(2, 1100, n, hr);
    chk("c_first_tick_delay", n, 1024);
    chk_frame("pre4", 2, 1024, 0, 24'h0, 256, 256, 256, 1'b0);
    repeat (100) @(negedge clk);
    chk1("c_led_before_reset", lr[2], 1'b1);
    #2 rst_v[2] = 1'b1;
    #1;
    chk1("async_reset_led_r", lr[2], 1'b0);
    chk1("async_reset_led_g", lg[2], 1'b0);
    chk1("async_reset_led_b", lb[2], 1'b0);
    chk1("async_reset_tick_busy", ft[2] | bz[2], 1'b0);
    @(negedge clk);
    rst_v[2] = 1'b0;
    wait_tick(2, 1100, n, hr);
    chk("c_restart_tick_delay", n, 1024);
    chk("c_restart_from_black", hr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
